// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit. It sequences fetch, decode, and execute
// through a Moore state machine for lw, sw, R-type, beq, addi and j.
// Outputs that depend only on the state are registered next to the state
// register. IRWrite, PCEn, illegal_op and the R-type ALUControl also depend
// on live inputs, so they are decoded combinationally from the current state.
module mips_multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       illegal_op,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control bundle that is a pure function of the state.
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    // Returns the state-only controls for state s. Unlisted fields stay 0,
    // and the ALU defaults to add.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = ALU_SUB;
                c.pc_src    = 2'b01;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_src = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       op_legal;
    logic       funct_legal;
    logic [2:0] funct_alu;

    // Decode the R-type function field into an ALU operation and a legality flag.
    always_comb begin
        funct_alu   = ALU_ADD;
        funct_legal = 1'b1;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    // Next-state logic. Unused codes 12-15 fall back to FETCH.
    always_comb begin
        state_d  = S_FETCH;
        op_legal = 1'b1;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
        ctrl_d = decode_state(state_d);
    end

    // Advance the state and register its controls together, so ctrl_q always matches state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Drive the outputs: registered state controls plus the input-qualified strobes.
    always_comb begin
        IorD       = ctrl_q.iord;
        MemWrite   = ctrl_q.mem_write;
        RegDst     = ctrl_q.reg_dst;
        MemtoReg   = ctrl_q.mem_to_reg;
        RegWrite   = ctrl_q.reg_write;
        ALUSrcA    = ctrl_q.alu_src_a;
        ALUSrcB    = ctrl_q.alu_src_b;
        PCSrc      = ctrl_q.pc_src;
        ALUControl = (state_q == S_EXECUTE) ? funct_alu : ctrl_q.alu_ctrl;
        IRWrite    = (state_q == S_FETCH) && mem_ready;
        PCEn       = ((state_q == S_FETCH) && mem_ready) ||
                     ((state_q == S_BRANCH) && zero) ||
                     (state_q == S_JUMP);
        illegal_op = ((state_q == S_DECODE) && !op_legal) ||
                     ((state_q == S_EXECUTE) && !funct_legal);
        state      = state_q;
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller. Every expected value
// below is computed by hand from the state-machine description.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mips_multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .illegal_op (illegal_op),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after inputs change.
    task automatic settle();
        #1;
    endtask

    // From FETCH with mem_ready=1, count the edges until the FSM is back in FETCH.
    task automatic run_latency(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input int exp_cycles);
        int n;
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (state != 4'd0 && n < 20);
        check(tag, n, exp_cycles);
    endtask

    logic [5:0] rfunct [4];
    logic [2:0] ralu   [4];

    initial begin
        rfunct[0] = 6'b100000; ralu[0] = 3'b010;
        rfunct[1] = 6'b100010; ralu[1] = 3'b110;
        rfunct[2] = 6'b100100; ralu[2] = 3'b000;
        rfunct[3] = 6'b100101; ralu[3] = 3'b001;

        reset = 1'b1; opcode = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        // During reset, the outputs follow the FETCH decode.
        check("rst_hold_state", state, 4'd0);
        check("rst_hold_srcb", ALUSrcB, 2'b01);
        reset = 1'b0;
        settle();

        // The cycle after reset is FETCH, with no register or memory write.
        check("rst_state", state, 4'd0);
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_iord", IorD, 1'b0);
        check("rst_alusrca", ALUSrcA, 1'b0);
        check("rst_alucontrol", ALUControl, 3'b010);
        check("rst_pcsrc", PCSrc, 2'b00);
        check("fetch_pcen", PCEn, 1'b1);
        check("fetch_irwrite", IRWrite, 1'b1);

        // lw walk: the state sequence is 0,1,2,3,4,0.
        tick();
        check("lw_s1", state, 4'd1);
        check("lw_dec_srcb", ALUSrcB, 2'b11);
        check("lw_dec_regwrite", RegWrite, 1'b0);
        tick();
        check("lw_s2", state, 4'd2);
        check("lw_adr_srca", ALUSrcA, 1'b1);
        check("lw_adr_srcb", ALUSrcB, 2'b10);
        tick();
        check("lw_s3", state, 4'd3);
        check("lw_rd_iord", IorD, 1'b1);
        check("lw_rd_regwrite", RegWrite, 1'b0);
        tick();
        check("lw_s4", state, 4'd4);
        check("lw_wb_regwrite", RegWrite, 1'b1);
        check("lw_wb_memtoreg", MemtoReg, 1'b1);
        check("lw_wb_regdst", RegDst, 1'b0);
        tick();
        check("lw_s0", state, 4'd0);
        check("lw_end_memtoreg", MemtoReg, 1'b0);

        // FETCH stalls while memory is not ready.
        mem_ready = 1'b0;
        settle();
        check("fetch_stall_pcen", PCEn, 1'b0);
        check("fetch_stall_irwrite", IRWrite, 1'b0);
        tick();
        check("fetch_stall_state", state, 4'd0);

        // sw with memory held off for 3 cycles: MemWrite stays high for 4 cycles.
        opcode = 6'b101011; mem_ready = 1'b1;
        tick();
        tick();
        check("sw_memadr", state, 4'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            check("sw_wait_state", state, 4'd5);
            check("sw_memwrite", MemWrite, 1'b1);
            check("sw_regwrite", RegWrite, 1'b0);
            tick();
        end
        check("sw_done_state", state, 4'd0);
        check("sw_done_memwrite", MemWrite, 1'b0);

        // R-type operations from a table of funct codes.
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            funct = rfunct[i];
            tick();
            tick();
            check("r_exec_state", state, 4'd6);
            check("r_exec_alu", ALUControl, ralu[i]);
            check("r_exec_illegal", illegal_op, 1'b0);
            tick();
            tick();
        end

        // slt: EXECUTE selects 111, then ALUWB writes to rd.
        funct = 6'b101010;
        tick();
        tick();
        check("slt_alu", ALUControl, 3'b111);
        check("slt_srca", ALUSrcA, 1'b1);
        check("slt_srcb", ALUSrcB, 2'b00);
        tick();
        check("slt_aluwb", state, 4'd7);
        check("slt_regdst", RegDst, 1'b1);
        check("slt_regwrite", RegWrite, 1'b1);
        tick();
        check("slt_back", state, 4'd0);

        // Unknown funct: add, illegal_op for one cycle, then ALUWB anyway.
        funct = 6'b111111;
        tick();
        tick();
        check("badfn_alu", ALUControl, 3'b010);
        check("badfn_illegal", illegal_op, 1'b1);
        tick();
        check("badfn_next", state, 4'd7);
        check("badfn_illegal_clear", illegal_op, 1'b0);
        tick();

        // beq taken: PCEn and PCSrc=01 in BRANCH.
        opcode = 6'b000100; zero = 1'b1;
        tick();
        tick();
        check("beq_state", state, 4'd8);
        check("beq_t_pcen", PCEn, 1'b1);
        check("beq_t_pcsrc", PCSrc, 2'b01);
        check("beq_t_alu", ALUControl, 3'b110);
        tick();
        check("beq_t_back", state, 4'd0);

        // beq not taken: PCEn stays low.
        zero = 1'b0;
        tick();
        tick();
        check("beq_nt_state", state, 4'd8);
        check("beq_nt_pcen", PCEn, 1'b0);
        tick();
        check("beq_nt_back", state, 4'd0);

        // addi: ADDIEX then ADDIWB.
        opcode = 6'b001000;
        tick();
        tick();
        check("addi_ex_state", state, 4'd9);
        check("addi_ex_srcb", ALUSrcB, 2'b10);
        tick();
        check("addi_wb_state", state, 4'd10);
        check("addi_wb_regwrite", RegWrite, 1'b1);
        check("addi_wb_regdst", RegDst, 1'b0);
        tick();

        // Illegal opcode: flagged only in DECODE, then back to FETCH with no writes.
        opcode = 6'b111111;
        settle();
        check("badop_fetch_illegal", illegal_op, 1'b0);
        tick();
        check("badop_illegal", illegal_op, 1'b1);
        check("badop_regwrite", RegWrite, 1'b0);
        check("badop_memwrite", MemWrite, 1'b0);
        tick();
        check("badop_next", state, 4'd0);
        check("badop_next_regwrite", RegWrite, 1'b0);

        // Reset while stalled in MEMRD, then run a jump.
        opcode = 6'b100011;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        settle();
        check("memrd_wait", state, 4'd3);
        tick();
        check("memrd_hold", state, 4'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("memrd_rst_state", state, 4'd0);
        check("memrd_rst_iord", IorD, 1'b0);
        check("memrd_rst_regwrite", RegWrite, 1'b0);
        opcode = 6'b000010; mem_ready = 1'b1;
        tick();
        tick();
        check("j_state", state, 4'd11);
        check("j_pcen", PCEn, 1'b1);
        check("j_pcsrc", PCSrc, 2'b10);
        tick();
        check("j_back", state, 4'd0);

        // Instruction latencies with mem_ready tied high.
        run_latency("lat_lw",   6'b100011, 6'b100000, 5);
        run_latency("lat_sw",   6'b101011, 6'b100000, 4);
        run_latency("lat_r",    6'b000000, 6'b100000, 4);
        run_latency("lat_addi", 6'b001000, 6'b100000, 4);
        run_latency("lat_beq",  6'b000100, 6'b100000, 3);
        run_latency("lat_j",    6'b000010, 6'b100000, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Count any cycle where RegWrite and MemWrite are both high.
    always @(negedge clk) begin
        if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL regwrite_memwrite_overlap got=1 expected=0");
        end
    end

endmodule
